// File: rtl/fft_pkg.sv
// Shared types for the first FFT butterfly stage sequencer.
// Holds the state encoding, the bit-reversal helper and the sample pair bundle.
package fft_pkg;

  localparam int BW   = 16;
  localparam int BR_W = 16;

  typedef enum logic [1:0] {
    LOAD,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [BW-1:0] re1;
    logic [BW-1:0] im1;
    logic [BW-1:0] re2;
    logic [BW-1:0] im2;
  } cpair_t;

  // Reverses the low w bits of a; upper bits come back zero.
  function automatic logic [BR_W-1:0] bitrev(
    input logic [BR_W-1:0] a,
    input int              w
  );
    bitrev = '0;
    for (int i = 0; i < BR_W; i++)
      if (i < w) bitrev[i] = a[w-1-i];
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// One-frame complex sample store: one write port, two async read ports.
// Contents survive reset; only the writer's counter is cleared.
module fft_frame_buf #(
  parameter int W  = 16,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wre,
  input  logic [W-1:0]  wim,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rre1,
  output logic [W-1:0]  rim1,
  output logic [W-1:0]  rre2,
  output logic [W-1:0]  rim2
);

  logic [W-1:0] mem_re [N];
  logic [W-1:0] mem_im [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_re[waddr] <= wre;
      mem_im[waddr] <= wim;
    end
  end

  assign rre1 = mem_re[raddr1];
  assign rim1 = mem_im[raddr1];
  assign rre2 = mem_re[raddr2];
  assign rim2 = mem_im[raddr2];

endmodule

// File: rtl/fft_first_stage_sched.sv
// Buffers a natural-order frame, feeds bit-reversed pairs to the
// external first-stage butterfly and registers its results downstream.
module fft_first_stage_sched
  import fft_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int N         = 8,
  parameter int LOG2N     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [bit_width-1:0] s_re,
  input  logic [bit_width-1:0] s_im,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [bit_width-1:0] bf_re_i1,
  output logic [bit_width-1:0] bf_im_i1,
  output logic [bit_width-1:0] bf_re_i2,
  output logic [bit_width-1:0] bf_im_i2,
  output logic                 bf_en,
  input  logic [bit_width-1:0] bf_re_o1,
  input  logic [bit_width-1:0] bf_im_o1,
  input  logic [bit_width-1:0] bf_re_o2,
  input  logic [bit_width-1:0] bf_im_o2,
  input  logic                 bf_out_valid,
  output logic [bit_width-1:0] m_re1,
  output logic [bit_width-1:0] m_im1,
  output logic [bit_width-1:0] m_re2,
  output logic [bit_width-1:0] m_im2,
  output logic [LOG2N-2:0]     m_idx,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic                 err
);

  localparam logic [LOG2N-1:0] WR_LAST = LOG2N'(N-1);
  localparam logic [LOG2N-2:0] P_LAST  = (LOG2N-1)'(N/2-1);

  state_t           state, state_n;
  logic [LOG2N-1:0] wr_cnt, wr_cnt_n;
  logic [LOG2N-2:0] p, p_n;
  logic [LOG2N-1:0] a1, a2;
  logic             accept, cap, err_n;
  cpair_t           m_q, bf_res;

  // bf_out_valid mirrors bf_en by contract and carries no extra info.
  logic unused_bf_valid;
  assign unused_bf_valid = bf_out_valid;

  assign s_ready = (state == LOAD) && !rst;
  assign accept  = s_valid && s_ready;
  assign bf_en   = (state == ISSUE) && (!m_valid || m_ready);

  assign a1 = LOG2N'(bitrev(BR_W'({p, 1'b0}), LOG2N));
  assign a2 = LOG2N'(bitrev(BR_W'({p, 1'b1}), LOG2N));

  fft_frame_buf #(
    .W (bit_width),
    .N (N),
    .AW(LOG2N)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_cnt),
    .wre   (s_re),
    .wim   (s_im),
    .raddr1(a1),
    .raddr2(a2),
    .rre1  (bf_re_i1),
    .rim1  (bf_im_i1),
    .rre2  (bf_re_i2),
    .rim2  (bf_im_i2)
  );

  assign bf_res = '{re1: bf_re_o1, im1: bf_im_o1,
                    re2: bf_re_o2, im2: bf_im_o2};

  always_comb begin
    state_n  = state;
    wr_cnt_n = wr_cnt;
    p_n      = p;
    err_n    = 1'b0;
    cap      = 1'b0;
    unique case (1'b1)
      (state == LOAD): begin
        if (accept) begin
          if (wr_cnt == WR_LAST) begin
            state_n  = ISSUE;
            wr_cnt_n = '0;
            err_n    = !s_last;
          end else if (s_last) begin
            wr_cnt_n = '0;
            err_n    = 1'b1;
          end else begin
            wr_cnt_n = wr_cnt + 1'b1;
          end
        end
      end
      (state == ISSUE): begin
        if (bf_en) begin
          cap = 1'b1;
          if (p == P_LAST) begin
            p_n     = '0;
            state_n = DRAIN;
          end else begin
            p_n = p + 1'b1;
          end
        end
      end
      (state == DRAIN): begin
        if (m_valid && m_ready) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      wr_cnt  <= '0;
      p       <= '0;
      err     <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_idx   <= '0;
      m_q     <= '0;
    end else begin
      state  <= state_n;
      wr_cnt <= wr_cnt_n;
      p      <= p_n;
      err    <= err_n;
      if (cap) begin
        m_q     <= bf_res;
        m_valid <= 1'b1;
        m_idx   <= p;
        m_last  <= (p == P_LAST);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign m_re1 = m_q.re1;
  assign m_im1 = m_q.im1;
  assign m_re2 = m_q.re2;
  assign m_im2 = m_q.im2;

endmodule

// File: tb/tb_fft_first_stage_sched.sv
// Directed bench for fft_first_stage_sched with a behavioural butterfly.
// Covers ordering, backpressure, frame-length errors, reset and wrap.
module tb_fft_first_stage_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_re, s_im;
  logic        s_valid, s_last, s_ready;
  logic [15:0] bf_re_i1, bf_im_i1, bf_re_i2, bf_im_i2;
  logic        bf_en;
  logic [15:0] bf_re_o1, bf_im_o1, bf_re_o2, bf_im_o2;
  logic [15:0] m_re1, m_im1, m_re2, m_im2;
  logic [1:0]  m_idx;
  logic        m_valid, m_last, m_ready, err;

  int checks = 0;
  int errors = 0;

  logic [15:0] smp  [8];
  logic [15:0] exp1 [4];
  logic [15:0] exp2 [4];

  always #5 clk = ~clk;

  // Reference radix-2 butterfly, wrapping at 16 bits.
  always_comb begin
    bf_re_o1 = bf_re_i1 + bf_re_i2;
    bf_im_o1 = bf_im_i1 + bf_im_i2;
    bf_re_o2 = bf_re_i1 - bf_re_i2;
    bf_im_o2 = bf_im_i1 - bf_im_i2;
  end

  fft_first_stage_sched #(
    .bit_width(16), .N(8), .LOG2N(3)
  ) dut (
    .clk(clk), .rst(rst),
    .s_re(s_re), .s_im(s_im),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .bf_re_i1(bf_re_i1), .bf_im_i1(bf_im_i1),
    .bf_re_i2(bf_re_i2), .bf_im_i2(bf_im_i2),
    .bf_en(bf_en),
    .bf_re_o1(bf_re_o1), .bf_im_o1(bf_im_o1),
    .bf_re_o2(bf_re_o2), .bf_im_o2(bf_im_o2),
    .bf_out_valid(bf_en),
    .m_re1(m_re1), .m_im1(m_im1), .m_re2(m_re2), .m_im2(m_im2),
    .m_idx(m_idx), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .err(err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input bit last_end);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_re    = smp[i];
      s_im    = 16'h0;
      s_last  = last_end && (i == n - 1);
      #1;
      chk("s_ready_load", {31'b0, s_ready}, 32'd1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic ramp(input int scale);
    for (int i = 0; i < 8; i++) smp[i] = 16'(i * scale);
  endtask

  // mode 0: m_ready held high; mode 1: 1,0,0,1,0 repeating.
  task automatic collect(input int mode);
    int          k;
    bit          held;
    logic [15:0] h_re1, h_re2;
    logic [1:0]  h_idx;
    k    = 0;
    held = 1'b0;
    h_re1 = '0;
    h_re2 = '0;
    h_idx = '0;
    for (int c = 0; c < 40; c++) begin
      m_ready = (mode == 0) ? 1'b1 : ((c % 5) == 0 || (c % 5) == 3);
      #1;
      if (held) begin
        chk("hold_re1", {16'b0, m_re1}, {16'b0, h_re1});
        chk("hold_re2", {16'b0, m_re2}, {16'b0, h_re2});
        chk("hold_idx", {30'b0, m_idx}, {30'b0, h_idx});
        held = 1'b0;
      end
      if (m_valid && !m_ready) begin
        chk("bf_en_stall", {31'b0, bf_en}, 32'd0);
        held  = 1'b1;
        h_re1 = m_re1;
        h_re2 = m_re2;
        h_idx = m_idx;
      end
      if (m_valid && m_ready) begin
        if (k < 4) begin
          chk("m_idx", {30'b0, m_idx}, 32'(k));
          chk("m_re1", {16'b0, m_re1}, {16'b0, exp1[k]});
          chk("m_re2", {16'b0, m_re2}, {16'b0, exp2[k]});
          chk("m_im1", {16'b0, m_im1}, 32'd0);
          chk("m_last", {31'b0, m_last}, (k == 3) ? 32'd1 : 32'd0);
          chk("err_issue", {31'b0, err}, 32'd0);
        end else begin
          chk("extra_pair", 32'(k), 32'd3);
        end
        k++;
      end
      tick();
      if (k >= 4) break;
    end
    chk("pair_count", 32'(k), 32'd4);
    m_ready = 1'b1;
    #1;
    chk("m_valid_after", {31'b0, m_valid}, 32'd0);
    chk("s_ready_after", {31'b0, s_ready}, 32'd1);
  endtask

  task automatic ramp_expect(input int scale);
    exp1[0] = 16'(4 * scale);  exp2[0] = 16'(-4 * scale);
    exp1[1] = 16'(8 * scale);  exp2[1] = 16'(-4 * scale);
    exp1[2] = 16'(6 * scale);  exp2[2] = 16'(-4 * scale);
    exp1[3] = 16'(10 * scale); exp2[3] = 16'(-4 * scale);
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_re    = '0;
    s_im    = '0;
    m_ready = 1'b1;
    tick();
    tick();
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_m_last", {31'b0, m_last}, 32'd0);
    chk("rst_m_idx", {30'b0, m_idx}, 32'd0);
    chk("rst_m_re1", {16'b0, m_re1}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("s_ready_idle", {31'b0, s_ready}, 32'd1);

    ramp(1);
    ramp_expect(1);
    send(8, 1'b1);
    chk("err_good", {31'b0, err}, 32'd0);
    chk("bf_en_issue", {31'b0, bf_en}, 32'd1);
    collect(0);

    send(8, 1'b1);
    collect(1);

    send(5, 1'b1);
    chk("err_short", {31'b0, err}, 32'd1);
    tick();
    chk("err_short_pulse", {31'b0, err}, 32'd0);
    tick();
    tick();
    chk("short_no_issue", {31'b0, m_valid}, 32'd0);
    chk("short_bf_en", {31'b0, bf_en}, 32'd0);
    chk("short_s_ready", {31'b0, s_ready}, 32'd1);
    ramp(1);
    send(8, 1'b1);
    collect(0);

    send(8, 1'b0);
    chk("err_nolast", {31'b0, err}, 32'd1);
    collect(0);

    send(8, 1'b1);
    tick();
    tick();
    chk("pre_rst_valid", {31'b0, m_valid}, 32'd1);
    chk("pre_rst_idx", {30'b0, m_idx}, 32'd1);
    chk("pre_rst_re1", {16'b0, m_re1}, 32'd8);
    rst = 1'b1;
    #1;
    chk("rst_hi_s_ready", {31'b0, s_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", {31'b0, m_valid}, 32'd0);
    chk("post_rst_s_ready", {31'b0, s_ready}, 32'd1);
    chk("post_rst_err", {31'b0, err}, 32'd0);
    ramp(10);
    ramp_expect(10);
    send(8, 1'b1);
    collect(0);

    for (int i = 0; i < 8; i++) smp[i] = 16'h0;
    smp[0] = 16'h7FFF;
    smp[4] = 16'h0001;
    exp1[0] = 16'h8000; exp2[0] = 16'h7FFE;
    for (int i = 1; i < 4; i++) begin
      exp1[i] = 16'h0;
      exp2[i] = 16'h0;
    end
    send(8, 1'b1);
    collect(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
